// File: rtl/omer_pkg.sv
// Shared types and constants for the kamus instruction fetch slice.
package omer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    FLUSH = 2'd3
  } fetch_state_e;

  localparam logic [31:0] PC_INCR = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/kamus_instr_fifo.sv
// Two-entry {pc, instr} buffer; entry 0 is always the head.
module kamus_instr_fifo
  import omer_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  fetch_entry_t push_entry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [1:0]   count_o,
  output fetch_entry_t head_o
);

  fetch_entry_t e0_q, e0_d, e1_q, e1_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (count_q == 2'd0) e0_d = push_entry_i;
          else                 e1_d = push_entry_i;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          e0_d    = e1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop: the new entry lands behind whatever remains.
          if (count_q == 2'd1) begin
            e0_d = push_entry_i;
          end else begin
            e0_d = e1_q;
            e1_d = push_entry_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      e0_q    <= '0;
      e1_q    <= '0;
      count_q <= '0;
    end else begin
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = (count_q != 2'd0) ? e0_q : '0;

endmodule

// File: rtl/kamus_fetch_ctrl.sv
// Instruction fetch controller: request FSM, fetch PC and redirect handling
// in front of a two-entry instruction buffer.
module kamus_fetch_ctrl
  import omer_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_en_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);

  localparam logic [1:0] DEPTH_C = FIFO_DEPTH[1:0];

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         push, pop;
  logic [1:0]   count;
  fetch_entry_t push_entry, head;

  assign pop        = instr_valid_o & instr_ready_i & ~redirect_i;
  assign push_entry = '{pc: pc_q - PC_INCR, instr: imem_rdata_i};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    if (redirect_i) begin
      pc_d = word_align(redirect_pc_i);
      // FLUSH only while a granted request still owes a response after this edge.
      case (state_q)
        REQ:         state_d = imem_gnt_i ? FLUSH : (fetch_en_i ? REQ : IDLE);
        WAIT, FLUSH: state_d = imem_rvalid_i ? (fetch_en_i ? REQ : IDLE) : FLUSH;
        default:     state_d = fetch_en_i ? REQ : IDLE;
      endcase
    end else begin
      case (state_q)
        IDLE: if (fetch_en_i && count < DEPTH_C) state_d = REQ;
        REQ: begin
          if (imem_gnt_i) begin
            state_d = WAIT;
            pc_d    = pc_q + PC_INCR;
          end
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            push    = 1'b1;
            state_d = (fetch_en_i && (count + 2'd1 - {1'b0, pop}) < DEPTH_C) ? REQ : IDLE;
          end
        end
        FLUSH: if (imem_rvalid_i) state_d = fetch_en_i ? REQ : IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pc_q    <= word_align(RESET_PC);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  kamus_instr_fifo u_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .flush_i      (redirect_i),
    .count_o      (count),
    .head_o       (head)
  );

  assign imem_req_o    = (state_q == REQ);
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = (count != 2'd0);
  assign instr_o       = head.instr;
  assign instr_pc_o    = head.pc;

endmodule

// File: tb/tb_kamus_fetch_ctrl.sv
// Bench for kamus_fetch_ctrl: cycle vectors, directed corner sequences and a
// randomized run against a fetch-stream scoreboard with a memory model.
module tb_kamus_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en, gnt, rvalid, redirect, ready;
  logic [31:0] rdata, redirect_pc;
  logic        req, ivalid;
  logic [31:0] addr, instr, ipc;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  kamus_fetch_ctrl #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .fetch_en_i    (fetch_en),
    .imem_req_o    (req),
    .imem_addr_o   (addr),
    .imem_gnt_i    (gnt),
    .imem_rvalid_i (rvalid),
    .imem_rdata_i  (rdata),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_valid_o (ivalid),
    .instr_o       (instr),
    .instr_pc_o    (ipc),
    .instr_ready_i (ready)
  );

  typedef struct {
    logic        fe, gn, rv;
    logic [31:0] rd;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr, e_ipc;
  } vec_t;

  vec_t vt[14];

  function automatic vec_t mk(logic fe, logic gn, logic rv, logic [31:0] rd, logic rdy,
                              logic e_req, logic [31:0] e_addr, logic e_valid,
                              logic [31:0] e_instr, logic [31:0] e_ipc);
    vec_t v;
    v.fe = fe; v.gn = gn; v.rv = rv; v.rd = rd; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_instr = e_instr; v.e_ipc = e_ipc;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    fetch_en = 0; gnt = 0; rvalid = 0; rdata = '0;
    redirect = 0; redirect_pc = '0; ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    repeat (2) step();
    rst = 0;
  endtask

  localparam logic [31:0] D0 = 32'hA000_0000, D1 = 32'hA000_0001;
  localparam logic [31:0] D2 = 32'hA000_0002, D3 = 32'hA000_0003;

  initial begin
    logic        pend, prev_hold, granted;
    int unsigned pdelay, pops;
    logic [31:0] paddr, prev_addr, exp_pc;

    vt[0]  = mk(1,1,0,0 ,1, 0,32'h00,0,0 ,0);
    vt[1]  = mk(1,1,0,0 ,1, 1,32'h00,0,0 ,0);
    vt[2]  = mk(1,1,1,D0,1, 0,32'h04,0,0 ,0);
    vt[3]  = mk(1,1,0,0 ,1, 1,32'h04,1,D0,32'h0);
    vt[4]  = mk(1,1,1,D1,1, 0,32'h08,0,0 ,0);
    vt[5]  = mk(1,1,0,0 ,1, 1,32'h08,1,D1,32'h4);
    vt[6]  = mk(1,1,1,D2,1, 0,32'h0C,0,0 ,0);
    vt[7]  = mk(1,1,0,0 ,0, 1,32'h0C,1,D2,32'h8);
    vt[8]  = mk(1,1,1,D3,0, 0,32'h10,1,D2,32'h8);
    vt[9]  = mk(1,1,0,0 ,0, 0,32'h10,1,D2,32'h8);
    vt[10] = mk(1,1,0,0 ,1, 0,32'h10,1,D2,32'h8);
    vt[11] = mk(1,1,0,0 ,0, 0,32'h10,1,D3,32'hC);
    vt[12] = mk(1,1,0,0 ,1, 1,32'h10,1,D3,32'hC);
    vt[13] = mk(1,0,0,0 ,1, 0,32'h14,0,0 ,0);

    // Reset values while rst is held
    idle_inputs();
    rst = 1;
    step();
    chk("rst_req", {31'd0, req}, 0);
    chk("rst_valid", {31'd0, ivalid}, 0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_instr", instr, 0);
    chk("rst_ipc", ipc, 0);
    step();
    rst = 0;

    // Streaming, back-pressure and resume
    for (int i = 0; i < 14; i++) begin
      step();
      chk($sformatf("vec%0d_req", i), {31'd0, req}, {31'd0, vt[i].e_req});
      chk($sformatf("vec%0d_addr", i), addr, vt[i].e_addr);
      chk($sformatf("vec%0d_valid", i), {31'd0, ivalid}, {31'd0, vt[i].e_valid});
      chk($sformatf("vec%0d_instr", i), instr, vt[i].e_instr);
      chk($sformatf("vec%0d_ipc", i), ipc, vt[i].e_ipc);
      fetch_en = vt[i].fe; gnt = vt[i].gn; rvalid = vt[i].rv;
      rdata = vt[i].rd; ready = vt[i].rdy;
    end

    // Redirect in WAIT, late response must be dropped
    do_reset();
    fetch_en = 1; gnt = 1; ready = 1;
    step(); step();
    chk("r40_wait_addr", addr, 32'h4);
    redirect = 1; redirect_pc = 32'h1003; gnt = 0;
    step();
    redirect = 0;
    chk("r40_flush_req", {31'd0, req}, 0);
    chk("r40_flush_addr", addr, 32'h1000);
    chk("r40_flush_valid", {31'd0, ivalid}, 0);
    step(); step();
    chk("r40_flush2_req", {31'd0, req}, 0);
    rvalid = 1; rdata = 32'hDEAD_0000;
    step();
    rvalid = 0;
    chk("r40_drop_valid", {31'd0, ivalid}, 0);
    chk("r40_req", {31'd0, req}, 1);
    chk("r40_req_addr", addr, 32'h1000);
    gnt = 1;
    step();
    gnt = 0;
    chk("r40_wait_valid", {31'd0, ivalid}, 0);
    rvalid = 1; rdata = 32'hBEEF_0000;
    step();
    rvalid = 0;
    chk("r40_new_valid", {31'd0, ivalid}, 1);
    chk("r40_new_instr", instr, 32'hBEEF_0000);
    chk("r40_new_ipc", ipc, 32'h1000);

    // Redirect coinciding with the response
    do_reset();
    fetch_en = 1; gnt = 1; ready = 1;
    step(); step();
    gnt = 0; rvalid = 1; rdata = 32'h1234_5678;
    redirect = 1; redirect_pc = 32'h2000;
    step();
    rvalid = 0; redirect = 0;
    chk("r41_req", {31'd0, req}, 1);
    chk("r41_addr", addr, 32'h2000);
    chk("r41_valid", {31'd0, ivalid}, 0);
    step();
    chk("r41_hold_valid", {31'd0, ivalid}, 0);

    // Grant withheld, fetch_en dropped
    do_reset();
    fetch_en = 1; gnt = 0; ready = 0;
    step();
    fetch_en = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("r42_hold%0d_req", i), {31'd0, req}, 1);
      chk($sformatf("r42_hold%0d_addr", i), addr, 32'h0);
    end
    gnt = 1;
    step();
    gnt = 0;
    chk("r42_wait_req", {31'd0, req}, 0);
    rvalid = 1; rdata = 32'hCAFE_0001;
    step();
    rvalid = 0;
    chk("r42_valid", {31'd0, ivalid}, 1);
    chk("r42_instr", instr, 32'hCAFE_0001);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("r42_idle%0d_req", i), {31'd0, req}, 0);
    end

    // Asynchronous reset with one entry buffered and a request in WAIT
    do_reset();
    fetch_en = 1; gnt = 1; ready = 0;
    step(); step();
    rvalid = 1; rdata = 32'h7777_0000;
    step();
    rvalid = 0;
    step();
    chk("r43_pre_valid", {31'd0, ivalid}, 1);
    chk("r43_pre_addr", addr, 32'h8);
    #2 rst = 1;
    #1;
    chk("r43_async_req", {31'd0, req}, 0);
    chk("r43_async_valid", {31'd0, ivalid}, 0);
    chk("r43_async_instr", instr, 0);
    chk("r43_async_ipc", ipc, 0);
    chk("r43_async_addr", addr, 32'h0);
    step();
    rst = 0; gnt = 0;
    step();
    chk("r43_first_req", {31'd0, req}, 1);
    chk("r43_first_addr", addr, 32'h0);

    // Randomized run against fetch-stream scoreboard and memory model
    do_reset();
    pend = 0; pdelay = 0; paddr = '0; prev_hold = 0; prev_addr = '0;
    exp_pc = 32'h0; pops = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (req) chk("rnd_align", {30'd0, addr[1:0]}, 0);
      if (prev_hold) begin
        chk("rnd_req_held", {31'd0, req}, 1);
        chk("rnd_addr_stable", addr, prev_addr);
      end
      fetch_en    = ($urandom_range(0, 7) != 0);
      ready       = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom;
      gnt         = ($urandom_range(0, 2) != 0);
      if (pend && pdelay == 0) begin
        rvalid = 1; rdata = mem_word(paddr);
      end else if (!pend) begin
        rvalid = ($urandom_range(0, 3) == 0); rdata = $urandom;
      end else begin
        rvalid = 0; rdata = $urandom;
      end

      if (redirect) begin
        exp_pc = {redirect_pc[31:2], 2'b00};
      end else if (ivalid && ready) begin
        chk("rnd_pc", ipc, exp_pc);
        chk("rnd_instr", instr, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        pops++;
      end

      if (pend) begin
        if (pdelay == 0) pend = 0;
        else pdelay--;
      end
      granted = req && gnt;
      if (granted) begin
        chk("rnd_one_outstanding", {31'd0, pend}, 0);
        pend = 1; pdelay = $urandom_range(0, 3); paddr = addr;
      end
      prev_hold = req && !gnt && !redirect;
      prev_addr = addr;
      step();
    end
    chk("rnd_progress", {31'd0, pops >= 100}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/kamus_fetch_ctrl.md
KAMUS_FETCH_CTRL -- requirements
Module: kamus_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 2, is the number of instruction buffer entries; the only legal value is 2.
REQ-003 clk_i  input  1  single clock; all state is updated on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 fetch_en_i  input  1  permits new memory requests.
REQ-006 imem_req_o  output  1  instruction memory request.
REQ-007 imem_addr_o  output  32  request address; always word aligned.
REQ-008 imem_gnt_i  input  1  memory accepts the request this cycle.
REQ-009 imem_rvalid_i  input  1  read data valid.
REQ-010 imem_rdata_i  input  32  instruction word.
REQ-011 redirect_i  input  1  branch/jump/trap redirect.
REQ-012 redirect_pc_i  input  32  redirect target; bits [1:0] are ignored and forced to 0.
REQ-013 instr_valid_o  output  1  buffer head is valid for the decoder.
REQ-014 instr_o  output  32  buffer head instruction, driven to the instruction decoder input.
REQ-015 instr_pc_o  output  32  PC of the buffer head.
REQ-016 instr_ready_i  input  1  decoder/execute consumes the head this cycle.

Function
REQ-017 The state machine SHALL have states IDLE, REQ, WAIT and FLUSH; imem_req_o SHALL be 1 only in REQ, and imem_addr_o SHALL equal the fetch PC register.
REQ-018 IDLE->REQ SHALL occur when fetch_en_i=1, redirect_i=0, and the buffer count is less than 2.
REQ-019 In REQ, imem_req_o SHALL be held until imem_gnt_i=1, regardless of fetch_en_i; the grant SHALL move the state to WAIT and add 4 to the PC, wrapping modulo 2^32.
REQ-020 At most one request SHALL be outstanding.
REQ-021 In WAIT, imem_rvalid_i=1 SHALL push {PC of the granted request, imem_rdata_i} into the buffer.
REQ-022 On that same WAIT response edge, the next state SHALL be REQ if fetch_en_i=1 and the buffer count after the push and pop is less than 2; otherwise it SHALL be IDLE.
REQ-023 instr_valid_o SHALL be (count != 0), combinationally from registered state; instr_o and instr_pc_o SHALL show the head entry.
REQ-024 The head SHALL pop when instr_valid_o=1 and instr_ready_i=1.
REQ-025 A push and a pop in the same cycle SHALL leave count unchanged; entries SHALL leave in fetch order.
REQ-026 The buffer SHALL never overflow: the issue rule guarantees count + outstanding <= 2.
REQ-027 Latency: with grant in the REQ cycle and rvalid on the next cycle, instr_valid_o SHALL rise on the cycle after rvalid.
REQ-028 redirect_i=1 SHALL, in the same edge, load the PC with {redirect_pc_i[31:2],2'b00}, clear the buffer (count=0), and discard any pop in that cycle.
REQ-029 On redirect, the next state SHALL be FLUSH if a request is outstanding after this edge and its response has not arrived. This covers WAIT without rvalid, and REQ with imem_gnt_i=1.
REQ-030 On redirect, any response arriving in the redirect cycle SHALL be dropped, and the next state SHALL be REQ if fetch_en_i=1, else IDLE.
REQ-031 In FLUSH, the next imem_rvalid_i SHALL be dropped without a push; the state SHALL then go to REQ if fetch_en_i=1, else IDLE.
REQ-032 A redirect in FLUSH SHALL update the PC and remain in FLUSH.
REQ-033 imem_rvalid_i in IDLE or REQ SHALL be ignored.

Reset
REQ-034 While rst_i=1, the state SHALL be IDLE, PC=RESET_PC, count=0, imem_req_o=0 and instr_valid_o=0; instr_o and instr_pc_o SHALL be 0.
REQ-035 Reset asserted mid-transaction SHALL abandon the outstanding request; the memory is reset on the same rst_i.

Structure
REQ-036 The fetch_state_e enum (IDLE, REQ, WAIT, FLUSH) and a PC_INCR=4 constant SHALL live in omer_pkg.
REQ-037 The 2-entry {pc, instr} buffer SHALL be the sub-module kamus_instr_fifo, with push/pop/flush/count ports; the controller SHALL contain the FSM and PC.

Verification
REQ-038 Reset released with fetch_en_i=1, grant always 1, rvalid one cycle after grant, ready=1 -> instr_pc_o sequence 0x0,0x4,0x8, each instr_o equal to the memory word.
REQ-039 ready=0 for 10 cycles -> count saturates at 2, at most 2 grants issued, imem_req_o=0 afterwards; ready=1 -> fetching resumes in order.
REQ-040 Redirect to 0x1003 in WAIT without rvalid; response arrives 3 cycles later -> response dropped; next request address 0x1000; instr_valid_o stays 0 until the new response.
REQ-041 Redirect in the same cycle as imem_rvalid_i -> no push, next state REQ, imem_addr_o = target.
REQ-042 Grant held at 0 for 5 cycles with fetch_en_i dropped after 1 cycle -> imem_req_o stays 1 and imem_addr_o stays stable until grant; no further request after the response.
REQ-043 rst_i pulsed in WAIT with 1 entry buffered -> outputs return to reset values asynchronously; the first request after release is at RESET_PC.
